// File: rtl/alaw_pcm_rx.sv
// G.711 TDM receive framer: locks to frame sync, deserialises MSB-first octets,
// strips the even-bit inversion and queues {slot, code} in a 2-entry FIFO.
// Optional per-slot push mask when ALAW_RX_SLOT_MASK_EN is defined.
module alaw_pcm_rx #(
  parameter int unsigned SLOTS = 32,
  parameter int unsigned CW    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic             pcm_din,
  input  logic             pcm_fsync,
`ifdef ALAW_RX_SLOT_MASK_EN
  input  logic [SLOTS-1:0] slot_mask,
`endif
  output logic [7:0]       alaw_out,
  output logic [CW-1:0]    alaw_slot,
  output logic             alaw_valid,
  input  logic             alaw_ready,
  output logic             in_sync,
  output logic             frame_err,
  output logic             overrun
);

  typedef enum logic [0:0] {StHunt, StSync} state_e;

  state_e          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]   slot_cnt_q, slot_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            in_sync_q, in_sync_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;

  logic [7:0]      data0_q, data0_d, data1_q, data1_d;
  logic [CW-1:0]   slot0_q, slot0_d, slot1_q, slot1_d;
  logic            valid0_q, valid0_d, valid1_q, valid1_d;

  logic            frame_start;
  logic            slot_done;
  logic            slot_ok;
  logic            push;
  logic [7:0]      push_data;
  logic [CW-1:0]   next_slot;

  assign frame_start = (slot_cnt_q == '0) && (bit_cnt_q == 3'd7);
  assign push_data   = {shift_q[6:0], pcm_din} ^ 8'h55;
  assign next_slot   = (slot_cnt_q == CW'(SLOTS - 1)) ? '0 : slot_cnt_q + 1'b1;

`ifdef ALAW_RX_SLOT_MASK_EN
  logic [SLOTS-1:0] mask_sh;
  assign mask_sh = slot_mask >> slot_cnt_q;
  assign slot_ok = mask_sh[0];
`else
  assign slot_ok = 1'b1;
`endif

  // Framing state machine; only bit_en cycles advance it.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    slot_cnt_d  = slot_cnt_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    slot_done   = 1'b0;
    if (bit_en) begin
      case (state_q)
        StHunt: begin
          if (pcm_fsync) begin
            state_d    = StSync;
            shift_d    = {shift_q[6:0], pcm_din};
            bit_cnt_d  = 3'd6;
            slot_cnt_d = '0;
          end
        end
        StSync: begin
          if (pcm_fsync && !frame_start) begin
            // Early sync: this bit becomes slot 0 bit 7, partial octet dropped.
            frame_err_d = 1'b1;
            shift_d     = {shift_q[6:0], pcm_din};
            bit_cnt_d   = 3'd6;
            slot_cnt_d  = '0;
          end else if (!pcm_fsync && frame_start) begin
            frame_err_d = 1'b1;
            state_d     = StHunt;
            bit_cnt_d   = 3'd7;
            slot_cnt_d  = '0;
          end else begin
            shift_d = {shift_q[6:0], pcm_din};
            if (bit_cnt_q == 3'd0) begin
              slot_done  = 1'b1;
              bit_cnt_d  = 3'd7;
              slot_cnt_d = next_slot;
            end else begin
              bit_cnt_d = bit_cnt_q - 3'd1;
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end
    in_sync_d = (state_d == StSync);
  end

  assign push = slot_done && slot_ok;

  // Two-entry FIFO: pop applied before push so a full FIFO being drained accepts.
  always_comb begin
    data0_d   = data0_q;
    slot0_d   = slot0_q;
    valid0_d  = valid0_q;
    data1_d   = data1_q;
    slot1_d   = slot1_q;
    valid1_d  = valid1_q;
    overrun_d = overrun_q;
    if (valid0_q && alaw_ready) begin
      data0_d  = data1_q;
      slot0_d  = slot1_q;
      valid0_d = valid1_q;
      valid1_d = 1'b0;
    end
    if (push) begin
      if (!valid0_d) begin
        data0_d  = push_data;
        slot0_d  = slot_cnt_q;
        valid0_d = 1'b1;
      end else if (!valid1_d) begin
        data1_d  = push_data;
        slot1_d  = slot_cnt_q;
        valid1_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StHunt;
      bit_cnt_q   <= 3'd7;
      slot_cnt_q  <= '0;
      shift_q     <= '0;
      in_sync_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      data0_q     <= '0;
      slot0_q     <= '0;
      valid0_q    <= 1'b0;
      data1_q     <= '0;
      slot1_q     <= '0;
      valid1_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      slot_cnt_q  <= slot_cnt_d;
      shift_q     <= shift_d;
      in_sync_q   <= in_sync_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      data0_q     <= data0_d;
      slot0_q     <= slot0_d;
      valid0_q    <= valid0_d;
      data1_q     <= data1_d;
      slot1_q     <= slot1_d;
      valid1_q    <= valid1_d;
    end
  end

  assign alaw_out   = data0_q;
  assign alaw_slot  = slot0_q;
  assign alaw_valid = valid0_q;
  assign in_sync    = in_sync_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_alaw_pcm_rx.sv
// Scoreboard bench for alaw_pcm_rx: expected {slot, code} pairs are queued as
// octets are sent and compared as the DUT hands words over.
module tb_alaw_pcm_rx;
  localparam int unsigned SLOTS = 32;
  localparam int unsigned CW    = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bit_en = 1'b0;
  logic          pcm_din = 1'b0;
  logic          pcm_fsync = 1'b0;
  logic [7:0]    alaw_out;
  logic [CW-1:0] alaw_slot;
  logic          alaw_valid;
  logic          alaw_ready = 1'b0;
  logic          in_sync;
  logic          frame_err;
  logic          overrun;
`ifdef ALAW_RX_SLOT_MASK_EN
  logic [SLOTS-1:0] slot_mask = '1;
`endif

  alaw_pcm_rx #(.SLOTS(SLOTS), .CW(CW)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .bit_en     (bit_en),
    .pcm_din    (pcm_din),
    .pcm_fsync  (pcm_fsync),
`ifdef ALAW_RX_SLOT_MASK_EN
    .slot_mask  (slot_mask),
`endif
    .alaw_out   (alaw_out),
    .alaw_slot  (alaw_slot),
    .alaw_valid (alaw_valid),
    .alaw_ready (alaw_ready),
    .in_sync    (in_sync),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int words = 0;
  int err_cycles = 0;
  logic [13:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_word(input int slot, input logic [7:0] code);
    exp_q.push_back({6'(slot), code});
  endtask

  // Monitor on the falling edge, away from input changes and DUT updates.
  logic          hold_q = 1'b0;
  logic [7:0]    hold_out;
  logic [CW-1:0] hold_slot;
  always @(negedge clk) begin
    logic [13:0] e;
    if (rst) begin
      hold_q = 1'b0;
    end else begin
      if (frame_err) err_cycles++;
      if (hold_q) begin
        check_eq("valid_held", {31'b0, alaw_valid}, 32'd1);
        check_eq("out_stable", {24'b0, alaw_out}, {24'b0, hold_out});
        check_eq("slot_stable", {26'b0, alaw_slot}, {26'b0, hold_slot});
      end
      if (alaw_valid && alaw_ready) begin
        words++;
        if (exp_q.size() == 0) begin
          check_eq("unexpected_word", {18'b0, alaw_slot, alaw_out}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check_eq("word_code", {24'b0, alaw_out}, {24'b0, e[7:0]});
          check_eq("word_slot", {26'b0, alaw_slot}, {26'b0, e[13:8]});
        end
      end
      hold_q    = alaw_valid && !alaw_ready;
      hold_out  = alaw_out;
      hold_slot = alaw_slot;
    end
  end

  // Returns one cycle after the capturing edge, so registered effects are visible.
  task automatic send_bit(input logic d, input logic fs);
    repeat (3) @(posedge clk);
    #1;
    bit_en = 1'b1; pcm_din = d; pcm_fsync = fs;
    @(posedge clk);
    #1;
    bit_en = 1'b0; pcm_fsync = 1'b0;
  endtask

  task automatic send_slot(input logic [7:0] b, input logic fs_first);
    for (int i = 7; i >= 0; i--) send_bit(b[i], (i == 7) && fs_first);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check_eq(tag, exp_q.size(), 0);
  endtask

  int base;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("rst_valid", {31'b0, alaw_valid}, 0);
    check_eq("rst_out", {24'b0, alaw_out}, 0);
    check_eq("rst_slot", {26'b0, alaw_slot}, 0);
    check_eq("rst_in_sync", {31'b0, in_sync}, 0);
    check_eq("rst_frame_err", {31'b0, frame_err}, 0);
    check_eq("rst_overrun", {31'b0, overrun}, 0);

    // Lock and single word: D5 ^ 55 = 80, visible the cycle after bit 0.
    send_slot(8'hD5, 1'b1);
    check_eq("lock_valid", {31'b0, alaw_valid}, 1);
    check_eq("lock_out", {24'b0, alaw_out}, 32'h80);
    check_eq("lock_slot", {26'b0, alaw_slot}, 0);
    check_eq("lock_in_sync", {31'b0, in_sync}, 1);
    expect_word(0, 8'h80);
    alaw_ready = 1'b1;
    for (int k = 1; k < 32; k++) begin
      send_slot(8'(k) ^ 8'h55, 1'b0);
      expect_word(k, 8'(k));
    end

    // Full frame with fsync at frame start
    for (int k = 0; k < 32; k++) begin
      send_slot(8'(k) ^ 8'h55, k == 0);
      expect_word(k, 8'(k));
    end
    drain("frame_drain");
    check_eq("frame_no_err", err_cycles, 0);

    // Sync loss: fsync missing at next frame start
    base = words;
    send_bit(1'b0, 1'b0);
    check_eq("loss_err", {31'b0, frame_err}, 1);
    check_eq("loss_in_sync", {31'b0, in_sync}, 0);
    for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
    check_eq("loss_no_word", words - base, 0);
    check_eq("loss_err_count", err_cycles, 1);
    send_slot(8'h12 ^ 8'h55, 1'b1);
    check_eq("relock_in_sync", {31'b0, in_sync}, 1);
    expect_word(0, 8'h12);

    // Early fsync at slot 3 bit 4
    send_slot(8'h01 ^ 8'h55, 1'b0);
    expect_word(1, 8'h01);
    send_slot(8'h02 ^ 8'h55, 1'b0);
    expect_word(2, 8'h02);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    send_slot(8'h6C ^ 8'h55, 1'b1);
    expect_word(0, 8'h6C);
    drain("early_drain");
    check_eq("early_err_count", err_cycles, 2);
    check_eq("early_in_sync", {31'b0, in_sync}, 1);
    for (int k = 1; k < 32; k++) begin
      send_slot(8'(k) ^ 8'h55, 1'b0);
      expect_word(k, 8'(k));
    end
    drain("early_frame_drain");

    // Backpressure over three slots
    alaw_ready = 1'b0;
    send_slot(8'h30 ^ 8'h55, 1'b1);
    expect_word(0, 8'h30);
    send_slot(8'h31 ^ 8'h55, 1'b0);
    expect_word(1, 8'h31);
    check_eq("bp_no_overrun", {31'b0, overrun}, 0);
    send_slot(8'h32 ^ 8'h55, 1'b0);
    check_eq("bp_overrun", {31'b0, overrun}, 1);
    check_eq("bp_head_out", {24'b0, alaw_out}, 32'h30);
    check_eq("bp_head_slot", {26'b0, alaw_slot}, 0);
    base = words;
    alaw_ready = 1'b1;
    drain("bp_drain");
    repeat (4) @(posedge clk);
    #1;
    check_eq("bp_words", words - base, 2);
    check_eq("bp_sticky", {31'b0, overrun}, 1);

    // Mid-frame reset with one word pending
    send_slot(8'h33 ^ 8'h55, 1'b0);
    expect_word(3, 8'h33);
    drain("pre_rst_drain");
    alaw_ready = 1'b0;
    send_slot(8'h44 ^ 8'h55, 1'b0);
    check_eq("pending_valid", {31'b0, alaw_valid}, 1);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_eq("mrst_valid", {31'b0, alaw_valid}, 0);
    check_eq("mrst_in_sync", {31'b0, in_sync}, 0);
    check_eq("mrst_overrun", {31'b0, overrun}, 0);
    alaw_ready = 1'b1;
    base = words;
    repeat (10) @(posedge clk);
    #1;
    check_eq("mrst_no_stale", words - base, 0);
    send_slot(8'hA7 ^ 8'h55, 1'b1);
    expect_word(0, 8'hA7);
    drain("relock_drain");
    check_eq("final_err_count", err_cycles, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/alaw_pcm_rx.md
Name: alaw_pcm_rx

Overview:
- Serial PCM (G.711 TDM) receive framer that sits directly upstream of the A-law decoder.
- Samples a bit-serial PCM line qualified by a bit strobe, locks to frame sync and deserialises MSB-first octets per timeslot.
- Removes the G.711 even-bit inversion (XOR 0x55) and presents each code as an 8-bit A-law word, with timeslot index, over a valid/ready handshake.
- The 8-bit output feeds the decoder's 8-bit A-law input directly.

Parameters:
- SLOTS, 32, timeslots per frame; legal range 2..64.
- CW, 6, timeslot index width; must satisfy 2^CW >= SLOTS.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- bit_en  input  1  one-cycle strobe; pcm_din and pcm_fsync are sampled only when high.
- pcm_din  input  1  serial PCM data, MSB of each octet first.
- pcm_fsync  input  1  frame sync; high on the bit_en of bit 7 (MSB) of slot 0.
- alaw_out  output  8  de-inverted A-law code.
- alaw_slot  output  CW  timeslot index of alaw_out.
- alaw_valid  output  1  output word available.
- alaw_ready  input  1  consumer accepts word when valid & ready.
- in_sync  output  1  high while state is SYNC.
- frame_err  output  1  one-cycle pulse on any sync violation.
- overrun  output  1  sticky; set when an octet is dropped because the FIFO is full.

Behaviour:
- Reset (synchronous, rst=1 at an edge) sets:
  - state HUNT;
  - bit counter 7, slot counter 0, shift register 0;
  - FIFO empty;
  - alaw_valid 0, alaw_out 0, alaw_slot 0;
  - in_sync 0, frame_err 0, overrun 0.
- Reset mid-frame discards any partial octet and all FIFO contents.
- Cycles with bit_en=0 change no framing state. FIFO pops still occur.
- HUNT state:
  - Shift register ignored.
  - On bit_en & pcm_fsync: go to SYNC. This bit is bit 7 of slot 0, so shift it in and set the bit counter to 6.
- SYNC state, on each bit_en:
  - Shift pcm_din into the LSB of the shift register.
  - Decrement the bit counter.
  - When the bit that completes a slot (bit 0) is taken, push {shift[6:0],pcm_din} ^ 8'h55 with the current slot index, then advance the slot counter.
  - The slot counter wraps SLOTS-1 -> 0.
- Sync checks, evaluated in SYNC on each bit_en:
  - Frame start = slot 0, bit 7.
  - fsync high at a non-frame-start position: pulse frame_err, drop the partial octet, realign so this bit is slot 0 bit 7, stay in SYNC.
  - fsync low at frame start: pulse frame_err, drop the bit, go to HUNT. No octet is pushed.
- frame_err is registered: it is high for exactly the cycle after the offending bit_en.
- FIFO:
  - 2 entries of {slot, octet}.
  - alaw_out, alaw_slot and alaw_valid come straight from the FIFO head registers.
  - Latency: the word appears with alaw_valid=1 in the cycle after the bit_en that completed the octet, provided the FIFO was empty.
- Handshake:
  - While alaw_valid=1 and alaw_ready=0, alaw_out and alaw_slot hold stable.
  - alaw_valid is never withdrawn before acceptance.
- Simultaneous push and pop: the pop is applied first, so a push into a full FIFO with alaw_ready=1 at the same edge succeeds.
- Push into a full FIFO with alaw_ready=0: the new octet is dropped, overrun is set, and the FIFO content is unchanged.
- overrun clears only on rst.
- in_sync is registered and equals (state==SYNC).

Optional Feature:
- Macro ALAW_RX_SLOT_MASK_EN.
- When defined:
  - Adds input port slot_mask, width SLOTS.
  - A completed octet whose slot_mask[slot]=0 is not pushed and cannot cause overrun.
  - slot_mask is sampled on the same bit_en that completes the octet.
- When undefined: the port is absent and every slot is pushed.

Test Plan:
- Lock and single word: rst, then bit_en every 4th cycle. Assert fsync on the first bit; slot 0 carries serial 8'hD5. Required: alaw_out=8'h80, alaw_slot=0, alaw_valid=1 the cycle after the 8th bit_en, in_sync=1.
- Full frame, SLOTS=32, ready=1: send slot k with serial byte k ^ 8'h55 for k=0..31, then fsync at the next frame start. Required: 32 words with alaw_out=k and alaw_slot=k in order; frame_err never pulses.
- Backpressure: hold ready=0 for 3 full slots. Required:
  - slots 0 and 1 are kept, stable and in order;
  - slot 2 is dropped and overrun=1;
  - after ready=1, exactly 2 words are delivered.
- Sync loss: omit fsync at the second frame start. Required: frame_err pulses once, in_sync=0, no word for that bit, re-lock on the next fsync.
- Early fsync: fsync at slot 3 bit 4. Required: frame_err pulses, no slot 3 word, the next word is slot 0 of the new alignment.
- Mid-frame reset: rst asserted at slot 5 bit 2 with one word pending. Required: alaw_valid=0, in_sync=0 and overrun=0 in the cycle after; no stale word after relock.
